rf_to_ram_writeback: RTL and testbench

Block-copy engine that moves a run of registers from the register file into the data RAM. It is the write-back counterpart of the load path, where the controller reads RAM and fills the regfile. On a start request it walks a source register range, issues synchronous regfile reads, and writes each word to consecutive RAM addresses on the RAM write port. It signals completion with a one-cycle done pulse.

---
 rtl/rf_to_ram_writeback.sv | 143 ++++++++++++++
 tb/tb_rf_to_ram_writeback.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rf_to_ram_writeback.sv
// Block-copy engine: streams a run of regfile words into consecutive RAM
// addresses, one word per cycle, and pulses done when the run is complete.
module rf_to_ram_writeback #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              ram_ena,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  n_s;

  // Requests larger than the memory depth are clamped to a full copy.
  always_comb begin
    if (count > DEPTH_C) begin
      n_s = DEPTH_C;
    end else begin
      n_s = count;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rem_q     <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rem_q     <= rem_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; the write side trails the read side by one cycle
  // because regfile data arrives a cycle after its address.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rem_d     = rem_q;
    wr_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    if (wr_q) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end else begin
      wr_addr_d = wr_addr_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_s != '0) begin
            state_d   = S_READ;
            rd_addr_d = src_base;
            wr_addr_d = dst_base;
            rem_d     = n_s;
            busy_d    = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        busy_d = 1'b1;
        wr_d   = 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = S_FLUSH;
          rem_d   = '0;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          rem_d     = rem_q - CNT_W'(1);
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Write data comes straight from the regfile read port; zero when idle.
  always_comb begin
    if (wr_q) begin
      ram_wdata = rf_rdata;
    end else begin
      ram_wdata = '0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rf_raddr = rd_addr_q;
  assign ram_ena  = wr_q;
  assign ram_we   = wr_q;
  assign ram_addr = wr_addr_q;

endmodule

// File: tb/tb_rf_to_ram_writeback.sv
// Self-checking bench for rf_to_ram_writeback: table vectors, random copies
// against a cycle-formula reference model, plus busy-start and reset sequences.
module tb_rf_to_ram_writeback;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int CW    = 7;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src_base, dst_base;
  logic [CW-1:0] count;
  logic          busy, done;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          ram_ena, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;

  logic [DW-1:0] rf_mem  [DEPTH];
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] exp_ram [DEPTH];
  int            exp_raddr;
  int            n_cmp = 0;
  int            n_err = 0;

  typedef struct {
    int src;
    int dst;
    int cnt;
    bit refill;
    int exp_done_c;
    int exp_writes;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  rf_to_ram_writeback #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_base(src_base), .dst_base(dst_base), .count(count),
    .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .ram_ena(ram_ena), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata)
  );

  // Synchronous-read regfile and write-only RAM models.
  always @(posedge clk) begin
    rf_rdata <= rf_mem[rf_raddr];
    if (ram_ena === 1'b1 && ram_we === 1'b1) ram_mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ram(input string name);
    int bad = 0;
    for (int k = 0; k < DEPTH; k++) if (ram_mem[k] !== exp_ram[k]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  // One copy starting in the current cycle (cycle 0); checks every cycle up to
  // the idle cycle after done, where the next copy may be requested.
  task automatic run_copy(input int src, input int dst, input int cnt,
                          input int busy_start_c,
                          output int done_c, output int writes);
    int n, last_c;
    bit e_busy, e_done, e_we;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    src_base = AW'(src); dst_base = AW'(dst); count = CW'(cnt); start = 1'b1;
    done_c = -1; writes = 0;
    last_c = (n > 0) ? n + 3 : 2;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk); #1;
      start = (c == busy_start_c);
      if (c == 1) begin
        src_base = AW'($urandom); dst_base = AW'($urandom); count = CW'($urandom);
      end
      if (c <= n) exp_raddr = (src + c - 1) % DEPTH;
      e_busy = (n > 0) && (c <= n + 1);
      e_done = (c == ((n > 0) ? n + 2 : 1));
      e_we   = (n > 0) && (c >= 2) && (c <= n + 1);
      if (done === 1'b1) done_c = c;
      if (ram_we === 1'b1) writes++;
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_ena", 32'(ram_ena), 32'(e_we));
      chk("rf_raddr", 32'(rf_raddr), 32'(exp_raddr));
      chk("no_x", 32'($isunknown({ram_addr, ram_wdata})), 32'd0);
      if (e_we) begin
        chk("ram_addr", 32'(ram_addr), 32'((dst + c - 2) % DEPTH));
        chk("ram_wdata", ram_wdata, rf_mem[(src + c - 2) % DEPTH]);
      end
    end
    for (int k = 0; k < n; k++) exp_ram[(dst + k) % DEPTH] = rf_mem[(src + k) % DEPTH];
  endtask

  initial begin
    int dc, wr, s, d, cn, n;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc, wr, s, d, cn, n;
    for (int k = 0; k < DEPTH; k++) begin
      rf_mem[k] = 32'(100 + k); ram_mem[k] = '0; exp_ram[k] = '0;
    end
    vecs[0] = '{4,  10, 3,   1'b0, 5,  3};
    vecs[1] = '{62, 63, 4,   1'b0, 6,  4};
    vecs[2] = '{7,  9,  0,   1'b0, 1,  0};
    vecs[3] = '{5,  33, 100, 1'b0, 66, 64};
    vecs[4] = '{0,  0,  64,  1'b1, 66, 64};

    rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; count = '0;
    repeat (3) @(posedge clk);
    #1;
    exp_raddr = 0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_ena", 32'(ram_ena), 32'd0);
    chk("rst_raddr", 32'(rf_raddr), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].refill) for (int k = 0; k < DEPTH; k++) rf_mem[k] = $urandom;
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].cnt, 0, dc, wr);
      chk("vec_done_cycle", 32'(dc), 32'(vecs[i].exp_done_c));
      chk("vec_writes", 32'(wr), 32'(vecs[i].exp_writes));
      chk_ram("vec_ram_image");
    end

    // start pulse while busy is ignored; start right after done is accepted
    run_copy(3, 30, 5, 3, dc, wr);
    chk("busy_start_done", 32'(dc), 32'd7);
    chk("busy_start_writes", 32'(wr), 32'd5);
    run_copy(40, 50, 2, 0, dc, wr);
    chk("after_done_start", 32'(dc), 32'd4);
    chk_ram("busy_start_ram");

    // reset in cycle 3 of an 8-word copy
    src_base = 6'd8; dst_base = 6'd20; count = 7'd8; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b0;
    exp_ram[20] = rf_mem[8]; exp_ram[21] = rf_mem[9];
    @(posedge clk); #1;
    exp_raddr = 0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(ram_we), 32'd0);
    chk("mid_rst_raddr", 32'(rf_raddr), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_we", 32'(ram_we), 32'd0);
    end
    chk_ram("mid_rst_ram");
    run_copy(60, 2, 6, 0, dc, wr);
    chk("post_rst_copy_done", 32'(dc), 32'd8);
    chk_ram("post_rst_ram");

    // random copies against the reference model
    for (int r = 0; r < 25; r++) begin
      if (r % 5 == 0) for (int k = 0; k < DEPTH; k++) rf_mem[k] = $urandom;
      s = $urandom_range(0, 63); d = $urandom_range(0, 63); cn = $urandom_range(0, 80);
      n = (cn > DEPTH) ? DEPTH : cn;
      run_copy(s, d, cn, 0, dc, wr);
      chk("rand_done_cycle", 32'(dc), 32'((n > 0) ? n + 2 : 1));
      chk("rand_writes", 32'(wr), 32'(n));
      chk_ram("rand_ram_image");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
